io_controller: RTL
==================

# io_controller

Memory-mapped I/O controller between the RV32I core's data-memory port and the board-level `io_input_bus`/`io_output_bus`. It is the parametrised successor of the core's fixed 14-bit-in/52-bit-out I/O. Widths are generics, and the block adds:
- input synchronisation and debouncing,
- rising-edge capture with write-1-to-clear pending bits and an interrupt line,
- byte-strobed output registers behind a single-cycle request/acknowledge bus.

## Interface
- `IN_WIDTH`, 14: number of input pins (1..32).
- `OUT_WIDTH`, 52: number of output pins (1..128). `NUM_OUT_WORDS = ceil(OUT_WIDTH/32)`.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised cycles required before an input change is accepted (≥1).
- `ADDR_WIDTH`, 8: byte-address width of the bus port.

Ports:
- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-low.
- `bus_req` in 1: access request, one per cycle.
- `bus_we` in 1: 1 = write, 0 = read.
- `bus_addr` in ADDR_WIDTH: byte address. Bits [1:0] are ignored.
- `bus_wdata` in 32: write data.
- `bus_wstrb` in 4: byte enables for writes.
- `bus_rdata` out 32: read data, valid while `bus_ack`=1.
- `bus_ack` out 1: access-complete pulse.
- `irq` out 1: level interrupt.
- `io_input_bus` in IN_WIDTH: asynchronous pins.
- `io_output_bus` out OUT_WIDTH: registered pins.

## Operation
Register map (word offsets):
- 0x00 IN (RO): debounced inputs, zero-extended.
- 0x04 PEND (R/W1C): rising-edge pending bits.
- 0x08 IRQ_EN (RW): per-bit interrupt enable.
- 0x10 + 4·k OUT[k] (RW), k < NUM_OUT_WORDS: output bits [32k+31:32k]. Bits ≥ OUT_WIDTH read 0 and ignore writes.
- Any other address: reads return 0, writes are ignored, the access is still acknowledged.

Input path, per bit:
- 2-flop synchroniser produces `sync`.
- Debounce: if `sync == deb`, `cnt <= 0`. Otherwise `cnt` increments; when `cnt == DEBOUNCE_CYCLES-1`, `deb <= sync` and `cnt <= 0`. `cnt` width is `clog2(DEBOUNCE_CYCLES+1)`.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches `deb`.

Edge capture:
- `PEND[i]` sets on a cycle where `deb[i]` goes 0→1.
- Writing 1 to `PEND[i]` (byte lane enabled) clears it.
- If a set and a clear occur in the same cycle, the set wins.

Interrupt:
- `irq = |(PEND & IRQ_EN)`, driven from registers only, with no combinational path from the bus.

Bus behaviour:
- Every `bus_req` is accepted; there is no stall.
- Writes take effect at the request edge, honouring `bus_wstrb` per byte.
- Reads sample register state before any same-cycle write.
- `bus_req` without `bus_we` and without `bus_wstrb` bits is a plain read.

Reset (`reset`=0 at a rising edge): clears synchronisers, `deb`, `cnt`, PEND, IRQ_EN, OUT, `bus_ack` and `bus_rdata`. After that edge, `io_output_bus`=0, `irq`=0, `bus_ack`=0, `bus_rdata`=0. Reset aborts any access in flight; no ack is issued for it.

## Timing
- Bus latency is exactly 1 cycle: `bus_ack` and `bus_rdata` are registered and high/valid in the cycle after `bus_req`. Back-to-back requests produce back-to-back acks.
- An OUT write is visible on `io_output_bus` in the cycle after the request edge.
- Pin change to `deb` update is 2 + DEBOUNCE_CYCLES edges. PEND and `irq` follow one edge later.
- An IRQ_EN write affects `irq` the cycle after the request edge. A PEND clear drops `irq` the cycle after the request edge, unless a new edge occurs that same cycle.

## Structure
- Package `io_ctrl_pkg` holds:
  - register offset constants (`IO_IN_OFS`, `IO_PEND_OFS`, `IO_IRQEN_OFS`, `IO_OUT_BASE`),
  - bus data width 32,
  - a `num_words(width)` function.
- Sub-module `io_debouncer` (parameters `WIDTH`, `DEBOUNCE_CYCLES`) contains the synchroniser and debounce counters and outputs `deb`. It is instantiated once, vector-wide.
- The top level holds the register file, edge detect, bus decode and ack/rdata registers.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with pins = 0x3FFF. Required: `io_output_bus`=0, `irq`=0, `bus_ack`=0, and a read of IN returns 0 until 2+4 edges after release.
- **Byte-strobed output write:** write 0xDEADBEEF to OUT[0] with `wstrb`=0b0101, then write 0xFFFFFFFF to OUT[1]. Required: `io_output_bus` = 0x0FFFFF00AD00EF, and a read of OUT[1] returns 0x000FFFFF.
- **Debounce:** pulse pin 3 high for 3 cycles. Required: IN reads 0. Then hold it high for 4+ cycles. Required: IN bit3 = 1 exactly at edge 6 after the change.
- **Edge and interrupt:** with IRQ_EN = 0x8 and pin 3 rising, `irq` rises one edge after `deb`. Write PEND = 0x8. Required: `irq`=0 the next cycle. Repeat with a simultaneous new edge. Required: PEND stays set.
- **Bus edge cases:** read 0x0C, then write 0x40, back-to-back. Required: two consecutive acks, `rdata`=0, no state change.
- **Reset mid-access:** assert `reset` in the cycle after `bus_req`. Required: `bus_ack`=0 in the following cycle.

Source files
------------

// File: rtl/io_ctrl_pkg.sv
// Shared constants for the memory-mapped I/O controller: register map and bus width.
package io_ctrl_pkg;

    localparam int BUS_DW = 32;

    localparam logic [31:0] IO_IN_OFS    = 32'h00;
    localparam logic [31:0] IO_PEND_OFS  = 32'h04;
    localparam logic [31:0] IO_IRQEN_OFS = 32'h08;
    localparam logic [31:0] IO_OUT_BASE  = 32'h10;

    // Number of bus words needed to cover a vector of the given width.
    function automatic int num_words(input int width);
        return (width + BUS_DW - 1) / BUS_DW;
    endfunction

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchroniser followed by a per-bit stability counter. An input
// change is accepted only after DEBOUNCE_CYCLES consecutive synchronised
// cycles that differ from the accepted value.
module io_debouncer #(
    parameter int WIDTH           = 14,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] deb
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync_ff1;
    logic [WIDTH-1:0]            sync_ff;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;

    // Bring asynchronous pins into the clock domain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_ff1 <= '0;
            sync_ff  <= '0;
        end else begin
            sync_ff1 <= pins;
            sync_ff  <= sync_ff1;
        end
    end

    // Any return to the accepted value restarts the count, so short glitches vanish.
    always_ff @(posedge clock) begin
        if (!reset) begin
            deb <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_ff[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync_ff[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/io_controller.sv
// Memory-mapped I/O controller: debounced inputs with rising-edge pending bits
// and a level interrupt, byte-strobed output registers, fixed 1-cycle bus ack.
module io_controller
    import io_ctrl_pkg::*;
#(
    parameter int IN_WIDTH        = 14,
    parameter int OUT_WIDTH       = 52,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bus_req,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [31:0]           bus_wdata,
    input  logic [3:0]            bus_wstrb,
    output logic [31:0]           bus_rdata,
    output logic                  bus_ack,
    output logic                  irq,
    input  logic [IN_WIDTH-1:0]   io_input_bus,
    output logic [OUT_WIDTH-1:0]  io_output_bus
);

    localparam int NUM_OUT_WORDS = num_words(OUT_WIDTH);
    localparam int OUT_PAD       = NUM_OUT_WORDS * BUS_DW;

    logic [IN_WIDTH-1:0]      deb, deb_q, rise;
    logic [IN_WIDTH-1:0]      pend_q, irqen_q, pend_clr, in_byte_en;
    logic [OUT_WIDTH-1:0]     out_q;
    logic [OUT_PAD-1:0]       out_ext;
    logic [31:0]              addr_word, rd_mux;
    logic                     wr_en;
    logic                     sel_pend, sel_irqen;
    logic [NUM_OUT_WORDS-1:0] sel_out;

    io_debouncer #(
        .WIDTH           (IN_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clock (clock),
        .reset (reset),
        .pins  (io_input_bus),
        .deb   (deb)
    );

    // Low address bits are masked rather than dropped so the whole port is consumed.
    assign addr_word = 32'(bus_addr) & ~32'h3;
    assign wr_en     = bus_req && bus_we;
    assign sel_pend  = (addr_word == IO_PEND_OFS);
    assign sel_irqen = (addr_word == IO_IRQEN_OFS);
    assign rise      = deb & ~deb_q;
    assign out_ext   = OUT_PAD'(out_q);
    assign irq       = |(pend_q & irqen_q);
    assign io_output_bus = out_q;

    // Address decode of output words and per-bit byte enables for the input-wide registers.
    always_comb begin
        sel_out    = '0;
        in_byte_en = '0;
        for (int k = 0; k < NUM_OUT_WORDS; k++)
            sel_out[k] = (addr_word == IO_OUT_BASE + 32'(4 * k));
        for (int i = 0; i < IN_WIDTH; i++)
            in_byte_en[i] = bus_wstrb[i / 8];
        pend_clr = (wr_en && sel_pend) ? (bus_wdata[IN_WIDTH-1:0] & in_byte_en) : '0;
    end

    // Read mux over pre-write register state; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        if (addr_word == IO_IN_OFS) rd_mux = 32'(deb);
        if (sel_pend)               rd_mux = 32'(pend_q);
        if (sel_irqen)              rd_mux = 32'(irqen_q);
        for (int k = 0; k < NUM_OUT_WORDS; k++)
            if (sel_out[k]) rd_mux = out_ext[k*BUS_DW +: BUS_DW];
    end

    // Edge capture, W1C pending (a new edge beats a same-cycle clear) and interrupt enables.
    always_ff @(posedge clock) begin
        if (!reset) begin
            deb_q   <= '0;
            pend_q  <= '0;
            irqen_q <= '0;
        end else begin
            deb_q  <= deb;
            pend_q <= (pend_q & ~pend_clr) | rise;
            if (wr_en && sel_irqen)
                for (int i = 0; i < IN_WIDTH; i++)
                    if (in_byte_en[i]) irqen_q[i] <= bus_wdata[i];
        end
    end

    // Output register bits; bits beyond OUT_WIDTH simply do not exist.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < OUT_WIDTH; i++)
                if (sel_out[i / BUS_DW] && bus_wstrb[(i % BUS_DW) / 8])
                    out_q[i] <= bus_wdata[i % BUS_DW];
        end
    end

    // Registered ack and read data, one cycle after every request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= (bus_req && !bus_we) ? rd_mux : '0;
        end
    end

endmodule
